// File: rtl/uart_pkg.sv
// Shared UART definitions: default datapath width and the tx arbiter state encoding.
package uart_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_START,
    ARB_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit searching ptr+1, ptr+2, ... modulo NumReq.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter int NumReq = 4,
  localparam int IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [NumReq-1:0]   grant,
  output logic [IdxWidth-1:0] idx,
  output logic                any_valid
);

  int cand;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = (int'(ptr) + i) % NumReq;
      if (!any_valid && req[IdxWidth'(cand)]) begin
        any_valid                = 1'b1;
        grant[IdxWidth'(cand)]   = 1'b1;
        idx                      = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmitter; valid in Idle -> ready next cycle -> tx_start_o one later.
// Backpressure: ready held low while tx_busy_i or a byte is in flight; a grant stalled for TimeoutCycles is force-released.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int DataWidth     = DATA_WIDTH,
  parameter int TimeoutCycles = 1024,
  localparam int IdxWidth     = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  input  logic [NumReq-1:0]           req_last_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        tx_start_o,
  output logic [DataWidth-1:0]        tx_data_o,
  input  logic                        tx_busy_i,
  input  logic                        tx_done_i,
  output logic [NumReq-1:0]           grant_o,
  output logic [IdxWidth-1:0]         grant_idx_o,
  output logic                        timeout_o
);

  localparam int CntWidth = $clog2(TimeoutCycles) + 1;

  arb_state_e           state_q;
  logic [IdxWidth-1:0]  ptr_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 last_q;
  logic [NumReq-1:0]    pick_grant;
  logic [IdxWidth-1:0]  pick_idx;
  logic                 pick_any;
  logic [DataWidth-1:0] sel_data;
  logic                 sel_last;
  logic                 hs;

  rr_pick #(.NumReq(NumReq)) u_rr_pick (
    .req       (req_valid_i),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Only the owner's lane is muxed and readied; other requesters simply wait.
  always_comb begin
    req_ready_o = '0;
    sel_data    = '0;
    sel_last    = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (grant_o[k]) begin
        sel_data       = req_data_i[k*DataWidth +: DataWidth];
        sel_last       = req_last_i[k];
        req_ready_o[k] = (state_q == ARB_GRANT) && req_valid_i[k] && !tx_busy_i;
      end
    end
  end

  assign hs = |req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= IdxWidth'(NumReq - 1);
      cnt_q       <= '0;
      last_q      <= 1'b0;
      grant_o     <= '0;
      grant_idx_o <= '0;
      tx_start_o  <= 1'b0;
      tx_data_o   <= '0;
      timeout_o   <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_o     <= pick_grant;
            grant_idx_o <= pick_idx;
            cnt_q       <= '0;
            state_q     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (hs) begin
            tx_data_o  <= sel_data;
            last_q     <= sel_last;
            tx_start_o <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ARB_START;
          end else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
            // Owner went quiet mid-message: hand the transmitter to the next requester.
            timeout_o   <= 1'b1;
            ptr_q       <= grant_idx_o;
            grant_o     <= '0;
            grant_idx_o <= '0;
            cnt_q       <= '0;
            state_q     <= ARB_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ARB_START: begin
          state_q <= ARB_WAIT_DONE;
        end
        ARB_WAIT_DONE: begin
          if (tx_done_i) begin
            if (last_q) begin
              ptr_q       <= grant_idx_o;
              grant_o     <= '0;
              grant_idx_o <= '0;
              state_q     <= ARB_IDLE;
            end else begin
              cnt_q   <= '0;
              state_q <= ARB_GRANT;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
